fifo_wr_arb: RTL and testbench
==============================

# fifo_wr_arb

Two-requester write-port arbiter for the asynchronous FIFO, running entirely in the write clock domain. It shares the FIFO's single write port (`wr_en`/`wr_data`, back-pressured by `full`) between two producers. In the UART, these are the host TX path and the internal loopback/test path. Arbitration is round-robin with a bounded burst length, so neither requester can starve the other.

## Interface
- `DATA_WIDTH`, 8, width of write data
- `BURST_MAX`, 4, maximum accepted beats per grant (1..255)
- `wr_clk`  in  1  write-domain clock
- `wr_rst`  in  1  asynchronous, active-high reset
- `req0_valid`  in  1  requester 0 has a word
- `req0_data`  in  DATA_WIDTH  requester 0 word
- `req0_ready`  out  1  requester 0 word accepted this cycle
- `req1_valid`  in  1  requester 1 has a word
- `req1_data`  in  DATA_WIDTH  requester 1 word
- `req1_ready`  out  1  requester 1 word accepted this cycle
- `full`  in  1  FIFO full flag, write domain
- `wr_en`  out  1  FIFO write strobe
- `wr_data`  out  DATA_WIDTH  FIFO write data
- `grant`  out  2  one-hot current owner; 00 = idle
- `beats0`, `beats1`  out  16  accepted-beat counters (see Configuration)

## Operation
- FSM states: IDLE, GNT0, GNT1. State, `last` (last owner, 1 bit) and `burst_cnt` (8 bits) are registered.
- `grant` = {state==GNT1, state==GNT0}.
- Accept condition in GNTn: `reqn_valid & ~full`.
  - On accept: `wr_en` = 1, `reqn_ready` = 1, `wr_data` = `reqn_data`. All three are combinational from state, valid and full.
  - The non-owner's ready is always 0.
  - When no accept occurs, `wr_data` = 0.
- Transitions from IDLE:
  - Both valid: grant the requester ≠ `last`.
  - One valid: grant that requester.
  - None valid: stay in IDLE.
- GNTn, accept with `burst_cnt` == BURST_MAX-1 (burst exhausted):
  - Other requester valid: go to GNTother.
  - Otherwise, `reqn_valid` still high: re-enter GNTn.
  - Otherwise: go to IDLE.
  - In every case `burst_cnt` is cleared and `last` is set to n.
- GNTn, `reqn_valid` low:
  - Go to GNTother if the other requester is valid, else IDLE.
  - `burst_cnt` is cleared and `last` is set to n.
- GNTn, accept not final: `burst_cnt` +1.
- GNTn, stalled by `full` with valid high: hold state and count. A stall never forfeits the grant.
- Only the grant-holding requester's valid is sampled for transitions. A requester dropping valid mid-burst never produces a write.

## Timing
- Reset (async assert): state = IDLE, `last` = 1 (requester 0 wins the first tie), `burst_cnt` = 0, `beats0`/`beats1` = 0.
  - Because `wr_en`/ready/`grant` decode from state, they go to 0 immediately when reset asserts, including mid-burst.
  - Release is synchronous to `wr_clk`.
- Latency from IDLE: valid seen at edge k → state GNTn after edge k → first accept in cycle k+1. Throughput is 1 beat/cycle within a grant.
- Handover between requesters costs zero idle cycles: the last beat of GNT0 is in cycle j, the first beat of GNT1 is in cycle j+1.
- `full` rising in the same cycle blocks the write that cycle. The arbiter does not retime `full`; the FIFO's write-side full logic must be conservative.
- Simultaneous burst exhaustion and other-requester valid: the handover takes priority over re-grant.
- BURST_MAX = 1 degenerates to strict per-beat alternation when both requesters are valid.

## Configuration
- `FIFO_ARB_STATS_EN` defined: `beats0`/`beats1` increment on each accept of their requester.
  - Counters are 16 bits and saturate at 0xFFFF (no wrap).
  - Counters are cleared only by reset.
- `FIFO_ARB_STATS_EN` undefined: no counter flops; `beats0`/`beats1` are tied to 0. Arbitration behaviour is identical.

## Test plan
- Reset mid-burst: assert `wr_rst` during GNT0 accept → `wr_en`=0, `grant`=00 in the same cycle. After release, with only req0 valid, the first accept occurs 1 cycle later.
- Both requesters continuously valid, BURST_MAX=4, `full`=0 → write sequence 4×req0, 4×req1, 4×req0, … with no idle cycles; `grant` toggles every 4 beats.
- Only req1 valid for 10 beats, BURST_MAX=4 → 10 consecutive writes. `grant` stays 10 throughout (re-grant); `last`=1 at each burst end.
- GNT0 with 2 beats done, `full` high for 5 cycles, req1 valid → no `wr_en`, grant held. After `full` drops, 2 more req0 beats, then handover to req1.
- req0 drops valid after 1 beat while req1 valid → next cycle GNT1, first req1 beat accepted. No write occurs in the cycle req0 is low.
- With `FIFO_ARB_STATS_EN`, 0x10000 req0 accepts → `beats0`=0xFFFF (saturated), `beats1` unchanged. Without the macro, both counters read 0.

Source files
------------

// File: rtl/fifo_wr_arb.sv
//-----------------------------------------------------------------------------
// fifo_wr_arb
//
// Two-requester round-robin arbiter for the asynchronous FIFO's write port.
// Runs entirely in the write clock domain. Each grant lasts at most BURST_MAX
// accepted beats, so neither producer can starve the other. A requester that
// is stalled by `full` keeps its grant. Handover to the other requester takes
// no idle cycles.
//
// Parameters:
//   DATA_WIDTH  width of the write data
//   BURST_MAX   maximum accepted beats per grant (1..255)
//
// Ports:
//   wr_clk      write-domain clock
//   wr_rst      asynchronous, active-high reset
//   req0_valid  requester 0 has a word
//   req0_data   requester 0 word
//   req0_ready  requester 0 word accepted this cycle
//   req1_valid  requester 1 has a word
//   req1_data   requester 1 word
//   req1_ready  requester 1 word accepted this cycle
//   full        FIFO full flag (write domain), used as-is, not retimed
//   wr_en       FIFO write strobe
//   wr_data     FIFO write data (0 when no write happens)
//   grant       one-hot current owner {GNT1, GNT0}; 00 = idle
//   beats0/1    accepted-beat counters for each requester
//
// Build option:
//   FIFO_ARB_STATS_EN  when defined, beats0/beats1 count accepts and
//                      saturate at 0xFFFF. When undefined, they are tied
//                      to 0 and no counter flops exist.
//-----------------------------------------------------------------------------
module fifo_wr_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  full,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [1:0]            grant,
  output logic [15:0]           beats0,
  output logic [15:0]           beats1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [7:0] BURST_LAST = 8'(BURST_MAX - 1);

  state_t     state, state_nxt;
  logic       last, last_nxt;           // last owner: 0 = req0, 1 = req1
  logic [7:0] burst_cnt, burst_cnt_nxt;

  logic acc0, acc1;

  // Accepts, and every output derived from them, decode from the state
  // register so they drop in the same cycle an asynchronous reset asserts.
  always_comb begin
    acc0 = (state == GNT0) & req0_valid & ~full;
    acc1 = (state == GNT1) & req1_valid & ~full;
  end

  always_comb begin
    grant      = {state == GNT1, state == GNT0};
    req0_ready = acc0;
    req1_ready = acc1;
    wr_en      = acc0 | acc1;
    wr_data    = '0;
    if (acc0)
      wr_data = req0_data;
    else if (acc1)
      wr_data = req1_data;
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state     <= IDLE;
      last      <= 1'b1;      // requester 0 wins the first tie
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Only the owner's valid decides whether the grant ends; the other
  // requester's valid only selects where the grant goes next.
  always_comb begin
    state_nxt     = state;
    last_nxt      = last;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid)
          state_nxt = last ? GNT0 : GNT1;
        else if (req0_valid)
          state_nxt = GNT0;
        else if (req1_valid)
          state_nxt = GNT1;
      end
      GNT0: begin
        if (!req0_valid) begin
          state_nxt     = req1_valid ? GNT1 : IDLE;
          burst_cnt_nxt = '0;
          last_nxt      = 1'b0;
        end else if (acc0) begin
          if (burst_cnt == BURST_LAST) begin
            // Handover beats re-grant; an accept implies req0_valid is
            // still high, so the re-grant path never falls through to IDLE.
            state_nxt     = req1_valid ? GNT1 : GNT0;
            burst_cnt_nxt = '0;
            last_nxt      = 1'b0;
          end else begin
            burst_cnt_nxt = burst_cnt + 8'd1;
          end
        end
      end
      GNT1: begin
        if (!req1_valid) begin
          state_nxt     = req0_valid ? GNT0 : IDLE;
          burst_cnt_nxt = '0;
          last_nxt      = 1'b1;
        end else if (acc1) begin
          if (burst_cnt == BURST_LAST) begin
            state_nxt     = req0_valid ? GNT0 : GNT1;
            burst_cnt_nxt = '0;
            last_nxt      = 1'b1;
          end else begin
            burst_cnt_nxt = burst_cnt + 8'd1;
          end
        end
      end
      default: begin
        state_nxt     = IDLE;
        burst_cnt_nxt = '0;
      end
    endcase
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] beats0_q, beats1_q;

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      beats0_q <= '0;
      beats1_q <= '0;
    end else begin
      if (acc0 && beats0_q != 16'hFFFF)
        beats0_q <= beats0_q + 16'd1;
      if (acc1 && beats1_q != 16'hFFFF)
        beats1_q <= beats1_q + 16'd1;
    end
  end

  assign beats0 = beats0_q;
  assign beats1 = beats1_q;
`else
  assign beats0 = '0;
  assign beats1 = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
module tb_fifo_wr_arb;

  localparam int DW = 8;
  localparam int BM = 4;

  logic          wr_clk = 1'b0;
  logic          wr_rst;
  logic          req0_valid, req1_valid, full;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready, wr_en;
  logic [DW-1:0] wr_data;
  logic [1:0]    grant;
  logic [15:0]   beats0, beats1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who owns the port, how many beats that owner has taken
  // in its current grant, who owned it last, and total accepts per requester.
  int m_owner = -1;     // -1 = nobody, 0 = req0, 1 = req1
  int m_used  = 0;
  int m_last  = 1;
  int m_b0    = 0;
  int m_b1    = 0;

  fifo_wr_arb #(.DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .wr_clk     (wr_clk),
    .wr_rst     (wr_rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .full       (full),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .grant      (grant),
    .beats0     (beats0),
    .beats1     (beats1)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic model_reset();
    m_owner = -1;
    m_used  = 0;
    m_last  = 1;
    m_b0    = 0;
    m_b1    = 0;
  endtask

  // Expected {grant, wr_en, req0_ready, req1_ready, wr_data, beats0, beats1}
  function automatic logic [44:0] exp_vec();
    logic [1:0]    g;
    logic          a0, a1;
    logic [DW-1:0] d;
    logic [15:0]   b0, b1;
    g  = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    a0 = (m_owner == 0) && req0_valid && !full;
    a1 = (m_owner == 1) && req1_valid && !full;
    d  = a0 ? req0_data : a1 ? req1_data : '0;
    b0 = 16'(m_b0);
    b1 = 16'(m_b1);
    return {g, a0 | a1, a0, a1, d, b0, b1};
  endfunction

  function automatic logic [44:0] dut_vec();
    return {grant, wr_en, req0_ready, req1_ready, wr_data, beats0, beats1};
  endfunction

  // Advance the model across one rising edge using the inputs held there.
  task automatic model_step();
    int  n;
    bit  vn, vo, a0, a1;
    if (wr_rst) begin
      model_reset();
      return;
    end
    a0 = (m_owner == 0) && req0_valid && !full;
    a1 = (m_owner == 1) && req1_valid && !full;
`ifdef FIFO_ARB_STATS_EN
    if (a0 && m_b0 < 65535) m_b0++;
    if (a1 && m_b1 < 65535) m_b1++;
`endif
    if (m_owner < 0) begin
      if (req0_valid && req1_valid) m_owner = 1 - m_last;
      else if (req0_valid)          m_owner = 0;
      else if (req1_valid)          m_owner = 1;
    end else begin
      n  = m_owner;
      vn = (n == 0) ? req0_valid : req1_valid;
      vo = (n == 0) ? req1_valid : req0_valid;
      if (!vn) begin
        m_last  = n;
        m_used  = 0;
        m_owner = vo ? 1 - n : -1;
      end else if (!full) begin
        m_used++;
        if (m_used == BM) begin
          m_used  = 0;
          m_last  = n;
          m_owner = vo ? 1 - n : n;
        end
      end
    end
  endtask

  task automatic rand_data();
    req0_data = DW'($urandom);
    req1_data = DW'($urandom);
  endtask

  task automatic test_reset();
    wr_rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; full = 1'b0;
    rand_data();
    model_reset();
    #1;
    n_checks++;
    if (dut_vec() !== exp_vec())
      $display("FAIL reset_state got=%h exp=%h", dut_vec(), exp_vec());
    else n_pass++;
    @(posedge wr_clk); model_step(); #1;
    wr_rst = 1'b0;
    // Start a req0 burst, then reset in the middle of an accepting cycle.
    for (int c = 0; c < 3; c++) begin
      req0_valid = 1'b1; rand_data();
      #3;
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL reset_pre cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      else n_pass++;
      @(posedge wr_clk); model_step(); #1;
    end
    wr_rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({grant, wr_en} !== 3'b000 || dut_vec() !== exp_vec())
      $display("FAIL reset_async got=%h exp=%h", dut_vec(), exp_vec());
    else n_pass++;
    #2;
    @(posedge wr_clk); model_step(); #1;
    wr_rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req0_valid = 1'b1; rand_data();
      #3;
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL reset_release cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      else n_pass++;
      n_checks++;
      if (wr_en !== (c != 0))
        $display("FAIL reset_first_accept cyc=%0d got=%b exp=%b", c, wr_en, c != 0);
      else n_pass++;
      @(posedge wr_clk); model_step(); #1;
    end
    req0_valid = 1'b0;
  endtask

  task automatic test_alternate();
    int writes = 0;
    for (int c = 0; c < 26; c++) begin
      req0_valid = 1'b1; req1_valid = 1'b1; full = 1'b0; rand_data();
      #3;
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL alternate cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      else n_pass++;
      if (wr_en) writes++;
      @(posedge wr_clk); model_step(); #1;
    end
    // Entered from GNT0 mid-burst; every cycle carries a write.
    n_checks++;
    if (writes != 26)
      $display("FAIL alternate_no_idle got=%0d exp=26", writes);
    else n_pass++;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_regrant();
    for (int c = 0; c < 14; c++) begin
      req0_valid = 1'b0; req1_valid = (c >= 2 && c < 13); full = 1'b0; rand_data();
      #3;
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL regrant cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      else n_pass++;
      if (c >= 3 && c < 13) begin
        n_checks++;
        if (grant !== 2'b10 || wr_en !== 1'b1)
          $display("FAIL regrant_hold cyc=%0d got=%b%b exp=101", c, grant, wr_en);
        else n_pass++;
      end
      @(posedge wr_clk); model_step(); #1;
    end
    req1_valid = 1'b0;
  endtask

  task automatic test_full_stall();
    // idle 2 cycles, then req0 alone for 3 cycles (grant + 2 beats),
    // then full for 5 cycles with req1 also valid, then release.
    for (int c = 0; c < 16; c++) begin
      req0_valid = (c >= 2);
      req1_valid = (c >= 5);
      full       = (c >= 5 && c < 10);
      rand_data();
      #3;
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL full_stall cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      else n_pass++;
      if (c >= 5 && c < 10) begin
        n_checks++;
        if (wr_en !== 1'b0 || grant !== 2'b01)
          $display("FAIL full_hold cyc=%0d got=%b%b exp=010", c, grant, wr_en);
        else n_pass++;
      end
      @(posedge wr_clk); model_step(); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; full = 1'b0;
    for (int c = 0; c < 8; c++) begin
      rand_data();
      #3;
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL full_drain cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      else n_pass++;
      @(posedge wr_clk); model_step(); #1;
    end
  endtask

  task automatic test_drop();
    for (int c = 0; c < 8; c++) begin
      req0_valid = (c < 2);
      req1_valid = (c >= 1);
      full = 1'b0; rand_data();
      #3;
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL drop cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      else n_pass++;
      @(posedge wr_clk); model_step(); #1;
    end
    req1_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      full       = ($urandom_range(0, 4) == 0);
      rand_data();
      #3;
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL random cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      else n_pass++;
      @(posedge wr_clk); model_step(); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; full = 1'b0;
  endtask

  task automatic test_stats();
    int          ncyc;
    logic [15:0] b1_start;
`ifdef FIFO_ARB_STATS_EN
    ncyc = 65540;
`else
    ncyc = 40;
`endif
    b1_start = beats1;
    for (int c = 0; c < ncyc; c++) begin
      req0_valid = 1'b1; req1_valid = 1'b0; full = 1'b0; rand_data();
      #3;
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL stats cyc=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
      else n_pass++;
      @(posedge wr_clk); model_step(); #1;
    end
    req0_valid = 1'b0;
    #3;
`ifdef FIFO_ARB_STATS_EN
    n_checks++;
    if (beats0 !== 16'hFFFF)
      $display("FAIL stats_saturate got=%h exp=ffff", beats0);
    else n_pass++;
    n_checks++;
    if (beats1 !== b1_start)
      $display("FAIL stats_beats1_unchanged got=%h exp=%h", beats1, b1_start);
    else n_pass++;
`else
    n_checks++;
    if (beats0 !== 16'h0 || beats1 !== 16'h0 || b1_start !== 16'h0)
      $display("FAIL stats_tied_zero got=%h/%h exp=0000/0000", beats0, beats1);
    else n_pass++;
`endif
    @(posedge wr_clk); model_step(); #1;
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_regrant();
    test_full_stall();
    test_drop();
    test_random();
    test_stats();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
